cpu_run_monitor: RTL and testbench
==================================

// Module: cpu_run_monitor
// PURPOSE
//  Synthesizable run monitor downstream of the multicycle cpu; consumes pc, memwrite, dataaddr, writedata.
//  Tracks progress, counts cycles and pc changes, and detects a stalled pc.
//  Decides pass/fail from a sentinel store (PASS_ADDR/PASS_DATA), so benches check one done flag.
// PARAMETERS
//  PC_INIT        PC_start       pc value expected while the cpu is held in reset
//  PASS_ADDR      32'h0000_0054  sentinel store address
//  PASS_DATA      32'd7          sentinel store data meaning pass
//  STALL_LIMIT    16             consecutive cycles with unchanged pc -> stall; minimum 2
//  TIMEOUT_CYCLES 4096           RUN cycles before timeout; minimum 2
// PORTS
//  clk          in   1   clock; rising edge
//  reset        in   1   asynchronous, active-low (0 = reset)
//  pc           in   32  cpu program counter
//  memwrite     in   1   cpu store strobe; one store per cycle it is high
//  dataaddr     in   32  store address
//  writedata    in   32  store data
//  done         out  1   terminal state reached; sticky
//  pass         out  1   sentinel matched; sticky
//  fail         out  1   bad sentinel, stall or timeout; sticky
//  reason       out  2   fail_reason_t: R_NONE, R_BADDATA, R_STALL, R_TIMEOUT
//  cycle_cnt    out  32  cycles spent in RUN
//  instr_cnt    out  32  count of cycles where pc differs from previous-cycle pc
//  last_wr_addr out  32  address of most recent store
//  last_wr_data out  32  data of most recent store
// BEHAVIOUR
//  Reset (async assert, sync release): state=S_IDLE; all outputs 0; prev_pc=PC_INIT; stall_cnt=0.
//  FSM states (mon_state_t):
//   S_IDLE -> S_RUN on first clock after reset release; unconditional.
//   S_RUN  -> S_PASS/S_FAIL as below.
//   S_PASS, S_FAIL: terminal; only reset leaves them.
//  S_RUN per cycle:
//   cycle_cnt+1; if pc!=prev_pc then instr_cnt+1 and stall_cnt=0, else stall_cnt+1; prev_pc<=pc.
//   memwrite=1 -> last_wr_addr/data updated same edge; this update occurs in every state except S_IDLE.
//  Exit priority when conditions coincide in one cycle:
//   1 memwrite && dataaddr==PASS_ADDR: writedata==PASS_DATA -> S_PASS, else S_FAIL with R_BADDATA.
//   2 stall_cnt reaches STALL_LIMIT-1 and pc is still unchanged -> S_FAIL with R_STALL.
//   3 cycle_cnt==TIMEOUT_CYCLES-1 -> S_FAIL with R_TIMEOUT.
//  Outputs are registered; done/pass/fail/reason update on the decision edge (latency 1 cycle).
//  Counters freeze in terminal states; 32-bit counters saturate at all-ones, no wrap.
//  Stores to addresses other than PASS_ADDR never end the run.
//  Reset mid-run: immediate return to reset values; no state is carried over.
//  pass and fail are never both 1; done == pass|fail.
// CONFIGURATION
//  MONITOR_TRACE_EN defined: simulation-only $display of each store (cycle, addr, data) and of the terminal verdict with reason.
//  MONITOR_TRACE_EN undefined: no display code; ports and cycle behaviour are identical.
// STRUCTURE
//  Common package (with u1/u32, PC_start):
//   - mon_state_t {S_IDLE,S_RUN,S_PASS,S_FAIL}
//   - fail_reason_t
//   - PASS_ADDR/PASS_DATA defaults
//  Sub-module pc_stall_detector:
//   - contains prev_pc register and stall counter
//   - inputs clk, reset, en, pc
//   - outputs pc_changed, stalled
//  Top: FSM, counters, store capture.
// TESTING
//  1 Release reset; pc advances by 4 every 5 cycles; store (0x54,7) at cycle 40
//    -> pass=1 at cycle 41, reason=R_NONE, instr_cnt=8.
//  2 Store (0x54,9) -> fail=1, reason=R_BADDATA, last_wr_data=9.
//  3 Hold pc constant 16 cycles after start, STALL_LIMIT=16
//    -> fail with R_STALL on 16th unchanged cycle; pc changes every 15 cycles -> never stalls.
//  4 TIMEOUT_CYCLES=64, pc incrementing, no sentinel -> fail, R_TIMEOUT, cycle_cnt=63 frozen.
//  5 Sentinel store and stall limit hit in same cycle -> pass=1 (priority).
//    Then pulse reset low mid-cycle -> all outputs 0 immediately.
//  6 Stores to 0x50 (data 3) then 0x54 (data 7)
//    -> last_wr_addr=0x50 after first, then pass with last_wr_addr=0x54.

Source files
------------

// File: rtl/cpu_run_monitor_pkg.sv
// Shared types and defaults for the cpu run monitor and its stall detector.
// Types and constants only; no timing or flow-control behaviour lives here.
package cpu_run_monitor_pkg;

    typedef logic        u1;
    typedef logic [31:0] u32;

    localparam u32 PC_start       = 32'h0000_0000;
    localparam u32 PASS_ADDR_DFLT = 32'h0000_0054;
    localparam u32 PASS_DATA_DFLT = 32'd7;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_PASS, S_FAIL} mon_state_t;
    typedef enum logic [1:0] {R_NONE, R_BADDATA, R_STALL, R_TIMEOUT} fail_reason_t;

    // Counters stick at all-ones instead of wrapping.
    function automatic u32 sat_inc(input u32 v);
        return (v == '1) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/cpu_run_monitor_if.sv
// CPU-side observation signals plus monitor verdict/statistics outputs.
// Plain wires; the monitor only observes the cpu and never backpressures it.
interface cpu_run_monitor_if;
    import cpu_run_monitor_pkg::*;

    u32           pc;
    u1            memwrite;
    u32           dataaddr;
    u32           writedata;

    u1            done;
    u1            pass;
    u1            fail;
    fail_reason_t reason;
    u32           cycle_cnt;
    u32           instr_cnt;
    u32           last_wr_addr;
    u32           last_wr_data;

    modport master (
        output pc, memwrite, dataaddr, writedata,
        input  done, pass, fail, reason, cycle_cnt, instr_cnt, last_wr_addr, last_wr_data
    );

    modport slave (
        input  pc, memwrite, dataaddr, writedata,
        output done, pass, fail, reason, cycle_cnt, instr_cnt, last_wr_addr, last_wr_data
    );

endinterface

// File: rtl/cpu_run_monitor_pc_stall_detector.sv
// Tracks previous pc and consecutive unchanged cycles; flags stall combinationally.
// pc_changed/stalled are same-cycle (0 latency); no backpressure.
module pc_stall_detector
    import cpu_run_monitor_pkg::*;
#(
    parameter u32 PC_INIT     = PC_start,
    parameter int STALL_LIMIT = 16
) (
    input  logic clk,
    input  logic reset,
    input  u1    en,
    input  u32   pc,
    output u1    pc_changed,
    output u1    stalled
);

    localparam int            CW         = $clog2(STALL_LIMIT + 1);
    localparam logic [CW-1:0] STALL_LAST = CW'(STALL_LIMIT - 1);

    u32            prev_pc_q, prev_pc_d;
    logic [CW-1:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        prev_pc_d   = prev_pc_q;
        stall_cnt_d = stall_cnt_q;
        pc_changed  = en && (pc != prev_pc_q);
        // The current cycle is the STALL_LIMIT-th unchanged one.
        stalled     = en && (pc == prev_pc_q) && (stall_cnt_q == STALL_LAST);
        if (en) begin
            prev_pc_d = pc;
            if (pc != prev_pc_q) begin
                stall_cnt_d = '0;
            end else if (stall_cnt_q != STALL_LAST) begin
                stall_cnt_d = stall_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            prev_pc_q   <= PC_INIT;
            stall_cnt_q <= '0;
        end else begin
            prev_pc_q   <= prev_pc_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

endmodule

// File: rtl/cpu_run_monitor.sv
// Run monitor: pass/fail verdict from sentinel store, stall or timeout; MONITOR_TRACE_EN adds sim trace.
// Verdict and counters registered (1-cycle latency); pure observer, never backpressures the cpu.
module cpu_run_monitor
    import cpu_run_monitor_pkg::*;
#(
    parameter u32 PC_INIT        = PC_start,
    parameter u32 PASS_ADDR      = PASS_ADDR_DFLT,
    parameter u32 PASS_DATA      = PASS_DATA_DFLT,
    parameter int STALL_LIMIT    = 16,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic              clk,
    input  logic              reset,
    cpu_run_monitor_if.slave  bus
);

    localparam u32 TIMEOUT_LAST = u32'(TIMEOUT_CYCLES - 1);

    mon_state_t   state_q, state_d;
    u1            pass_q, pass_d;
    u1            fail_q, fail_d;
    fail_reason_t reason_q, reason_d;
    u32           cycle_cnt_q, cycle_cnt_d;
    u32           instr_cnt_q, instr_cnt_d;
    u32           last_wr_addr_q, last_wr_addr_d;
    u32           last_wr_data_q, last_wr_data_d;
    u32           cycle_inc;
    u1            pc_changed;
    u1            stalled;

    pc_stall_detector #(
        .PC_INIT     (PC_INIT),
        .STALL_LIMIT (STALL_LIMIT)
    ) u_stall (
        .clk        (clk),
        .reset      (reset),
        .en         (state_q == S_RUN),
        .pc         (bus.pc),
        .pc_changed (pc_changed),
        .stalled    (stalled)
    );

    always_comb begin
        state_d        = state_q;
        pass_d         = pass_q;
        fail_d         = fail_q;
        reason_d       = reason_q;
        cycle_cnt_d    = cycle_cnt_q;
        instr_cnt_d    = instr_cnt_q;
        last_wr_addr_d = last_wr_addr_q;
        last_wr_data_d = last_wr_data_q;
        cycle_inc      = sat_inc(cycle_cnt_q);

        if (state_q != S_IDLE && bus.memwrite) begin
            last_wr_addr_d = bus.dataaddr;
            last_wr_data_d = bus.writedata;
        end

        case (state_q)
            S_IDLE: state_d = S_RUN;
            S_RUN: begin
                // The deciding cycle is still a RUN cycle, so it is counted too.
                cycle_cnt_d = cycle_inc;
                if (pc_changed) instr_cnt_d = sat_inc(instr_cnt_q);
                if (bus.memwrite && bus.dataaddr == PASS_ADDR) begin
                    if (bus.writedata == PASS_DATA) begin
                        state_d = S_PASS;
                        pass_d  = 1'b1;
                    end else begin
                        state_d  = S_FAIL;
                        fail_d   = 1'b1;
                        reason_d = R_BADDATA;
                    end
                end else if (stalled) begin
                    state_d  = S_FAIL;
                    fail_d   = 1'b1;
                    reason_d = R_STALL;
                end else if (cycle_inc == TIMEOUT_LAST) begin
                    state_d  = S_FAIL;
                    fail_d   = 1'b1;
                    reason_d = R_TIMEOUT;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q        <= S_IDLE;
            pass_q         <= 1'b0;
            fail_q         <= 1'b0;
            reason_q       <= R_NONE;
            cycle_cnt_q    <= '0;
            instr_cnt_q    <= '0;
            last_wr_addr_q <= '0;
            last_wr_data_q <= '0;
        end else begin
            state_q        <= state_d;
            pass_q         <= pass_d;
            fail_q         <= fail_d;
            reason_q       <= reason_d;
            cycle_cnt_q    <= cycle_cnt_d;
            instr_cnt_q    <= instr_cnt_d;
            last_wr_addr_q <= last_wr_addr_d;
            last_wr_data_q <= last_wr_data_d;
        end
    end

    assign bus.done         = pass_q | fail_q;
    assign bus.pass         = pass_q;
    assign bus.fail         = fail_q;
    assign bus.reason       = reason_q;
    assign bus.cycle_cnt    = cycle_cnt_q;
    assign bus.instr_cnt    = instr_cnt_q;
    assign bus.last_wr_addr = last_wr_addr_q;
    assign bus.last_wr_data = last_wr_data_q;

`ifdef MONITOR_TRACE_EN
    always @(posedge clk) begin
        if (reset && state_q != S_IDLE && bus.memwrite)
            $display("[MON] cycle %0d store addr=0x%08h data=0x%08h", cycle_cnt_q, bus.dataaddr, bus.writedata);
        if (reset && state_q == S_RUN && state_d != S_RUN)
            $display("[MON] verdict %s reason=%s", (state_d == S_PASS) ? "pass" : "fail", reason_d.name());
    end
`endif

endmodule

// File: tb/tb_cpu_run_monitor.sv
// Directed bench for cpu_run_monitor: sentinel pass/bad data, stall, timeout, priority, reset.
// Inputs driven #1 after the rising edge; outputs sampled at the same point.
module tb_cpu_run_monitor;
    import cpu_run_monitor_pkg::*;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    int   tests_run    = 0;
    int   tests_failed = 0;

    cpu_run_monitor_if bus();

    cpu_run_monitor #(
        .PC_INIT        (32'h0),
        .PASS_ADDR      (32'h54),
        .PASS_DATA      (32'd7),
        .STALL_LIMIT    (16),
        .TIMEOUT_CYCLES (64)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic [31:0] p, input logic we, input logic [31:0] a, input logic [31:0] d);
        bus.pc        = p;
        bus.memwrite  = we;
        bus.dataaddr  = a;
        bus.writedata = d;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        drive(32'h0, 1'b0, 32'h0, 32'h0);
        tick();
        tick();
        reset = 1'b1;
    endtask

    // Leaves the DUT in RUN, ready for RUN cycle 0 inputs.
    task automatic start(input logic idle_store);
        do_reset();
        drive(32'h0, idle_store, 32'h54, 32'd7);
        tick();
    endtask

    initial begin
        drive(32'h0, 1'b0, 32'h0, 32'h0);
        tick();
        check("rst_done",   32'(bus.done), 32'd0);
        check("rst_pass",   32'(bus.pass), 32'd0);
        check("rst_fail",   32'(bus.fail), 32'd0);
        check("rst_reason", 32'(bus.reason), 32'(R_NONE));
        check("rst_cycle",  bus.cycle_cnt, 32'd0);
        check("rst_instr",  bus.instr_cnt, 32'd0);
        check("rst_waddr",  bus.last_wr_addr, 32'd0);
        check("rst_wdata",  bus.last_wr_data, 32'd0);

        // Sentinel pass at RUN cycle 40; pc steps by 4 every 5 cycles. IDLE store is ignored.
        start(1'b1);
        check("t1_idle_store_ignored", bus.last_wr_addr, 32'd0);
        check("t1_idle_no_done", 32'(bus.done), 32'd0);
        for (int c = 0; c <= 40; c++) begin
            drive(32'(4 * (c / 5)), c == 40, 32'h54, 32'd7);
            tick();
            if (c == 39) check("t1_not_done_early", 32'(bus.done), 32'd0);
        end
        check("t1_pass",   32'(bus.pass), 32'd1);
        check("t1_fail",   32'(bus.fail), 32'd0);
        check("t1_done",   32'(bus.done), 32'd1);
        check("t1_reason", 32'(bus.reason), 32'(R_NONE));
        check("t1_instr",  bus.instr_cnt, 32'd8);
        check("t1_cycle",  bus.cycle_cnt, 32'd41);
        check("t1_waddr",  bus.last_wr_addr, 32'h54);
        drive(32'h100, 1'b1, 32'h54, 32'd9);
        tick();
        drive(32'h104, 1'b1, 32'h60, 32'd5);
        tick();
        check("t1_post_fail_stays0", 32'(bus.fail), 32'd0);
        check("t1_post_pass_sticky", 32'(bus.pass), 32'd1);
        check("t1_post_cycle_frozen", bus.cycle_cnt, 32'd41);
        check("t1_post_instr_frozen", bus.instr_cnt, 32'd8);
        check("t1_post_waddr", bus.last_wr_addr, 32'h60);
        check("t1_post_wdata", bus.last_wr_data, 32'd5);

        // Bad sentinel data.
        start(1'b0);
        for (int c = 0; c <= 3; c++) begin
            drive(32'(4 * c), c == 3, 32'h54, 32'd9);
            tick();
        end
        check("t2_fail",   32'(bus.fail), 32'd1);
        check("t2_pass",   32'(bus.pass), 32'd0);
        check("t2_done",   32'(bus.done), 32'd1);
        check("t2_reason", 32'(bus.reason), 32'(R_BADDATA));
        check("t2_wdata",  bus.last_wr_data, 32'd9);

        // pc held constant: stall on the 16th unchanged cycle.
        start(1'b0);
        for (int c = 0; c <= 15; c++) begin
            drive(32'h0, 1'b0, 32'h0, 32'h0);
            tick();
            if (c == 14) check("t3_no_stall_at_15", 32'(bus.done), 32'd0);
        end
        check("t3_fail",   32'(bus.fail), 32'd1);
        check("t3_reason", 32'(bus.reason), 32'(R_STALL));
        check("t3_cycle",  bus.cycle_cnt, 32'd16);
        check("t3_instr",  bus.instr_cnt, 32'd0);

        // pc changes every 15 cycles: never stalls, ends by timeout.
        start(1'b0);
        for (int c = 0; c <= 62; c++) begin
            drive(32'(4 * (c / 15)), 1'b0, 32'h0, 32'h0);
            tick();
            if (c == 61) check("t3b_not_done_early", 32'(bus.done), 32'd0);
        end
        check("t3b_reason", 32'(bus.reason), 32'(R_TIMEOUT));
        check("t3b_instr",  bus.instr_cnt, 32'd4);

        // Timeout with pc incrementing every cycle.
        start(1'b0);
        for (int c = 0; c <= 62; c++) begin
            drive(32'(4 * (c + 1)), 1'b0, 32'h0, 32'h0);
            tick();
        end
        check("t4_fail",   32'(bus.fail), 32'd1);
        check("t4_reason", 32'(bus.reason), 32'(R_TIMEOUT));
        check("t4_cycle",  bus.cycle_cnt, 32'd63);
        check("t4_instr",  bus.instr_cnt, 32'd63);
        for (int c = 0; c < 3; c++) begin
            drive(32'(1000 + 4 * c), 1'b0, 32'h0, 32'h0);
            tick();
        end
        check("t4_cycle_frozen", bus.cycle_cnt, 32'd63);
        check("t4_instr_frozen", bus.instr_cnt, 32'd63);

        // Sentinel and stall limit in the same cycle: pass wins.
        start(1'b0);
        for (int c = 0; c <= 15; c++) begin
            drive(32'h0, c == 15, 32'h54, 32'd7);
            tick();
        end
        check("t5_pass",   32'(bus.pass), 32'd1);
        check("t5_fail",   32'(bus.fail), 32'd0);
        check("t5_reason", 32'(bus.reason), 32'(R_NONE));
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("t5_rst_done",  32'(bus.done), 32'd0);
        check("t5_rst_pass",  32'(bus.pass), 32'd0);
        check("t5_rst_cycle", bus.cycle_cnt, 32'd0);
        check("t5_rst_instr", bus.instr_cnt, 32'd0);
        check("t5_rst_waddr", bus.last_wr_addr, 32'd0);

        // Non-sentinel store then sentinel.
        start(1'b0);
        drive(32'h4, 1'b0, 32'h0, 32'h0);
        tick();
        drive(32'h8, 1'b1, 32'h50, 32'd3);
        tick();
        check("t6_waddr_first", bus.last_wr_addr, 32'h50);
        check("t6_wdata_first", bus.last_wr_data, 32'd3);
        check("t6_not_done",    32'(bus.done), 32'd0);
        drive(32'hC, 1'b1, 32'h54, 32'd7);
        tick();
        check("t6_pass",  32'(bus.pass), 32'd1);
        check("t6_waddr", bus.last_wr_addr, 32'h54);
        check("t6_wdata", bus.last_wr_data, 32'd7);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
